spectro_readout_seq: RTL and testbench

- Parametrised readout sequencer for ping-pong acquisition memory. Each acoustic event becomes one serial frame: RTC timestamp, then every stored word of each bank that event filled.
- Sits between the bank-write logic (bank_full / acq_done pulses) and the serial output link.
- Generalises the fixed 2x200-word, free-running readout:
  - widths and depth are parameters;
  - a 2-entry job queue with overflow flag;
  - downstream valid/ready backpressure;
  - explicit frame delimiters.

---
 rtl/spectro_readout_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_spectro_readout_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spectro_readout_seq.sv
// rtl/spectro_readout_seq.sv - ping-pong acquisition memory readout sequencer
//
// Turns each acoustic event into one serial frame: the RTC timestamp (MSB
// first) followed by every stored word of each bank the event filled.
// A 2-entry job queue sits between the bank-write pulses and the serialiser;
// the serial link uses valid/ready backpressure.
//
// Optional build macro: READOUT_PARITY_EN
//   defined     - each memory word is followed by one even-parity bit
//   not defined - each memory word is exactly WORD_W bits
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   bank_full, acq_done   1-cycle pulses from the bank-write logic
//   last_addr             last word index written (valid with acq_done)
//   timestamp             free-running RTC value
//   rd_en, rd_addr        memory read strobe and {bank, word index}
//   rd_data               memory data, valid one cycle after rd_en
//   ser_data, ser_valid   serial bit stream (MSB first) and its valid
//   ser_ready             downstream accepts a bit when valid & ready
//   frame_start           high on the first timestamp bit
//   frame_end             high on the last bit of the frame
//   busy                  sequencer active or jobs pending
//   overflow              sticky: a job was dropped on a full queue
//   state                 current state encoding

module spectro_readout_seq #(
  parameter int TS_W   = 30,
  parameter int WORD_W = 8,
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bank_full,
  input  logic              acq_done,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [TS_W-1:0]   timestamp,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy,
  output logic              overflow,
  output logic [2:0]        state
);

`ifdef READOUT_PARITY_EN
  localparam int WBITS = WORD_W + 1;
`else
  localparam int WBITS = WORD_W;
`endif

  // One shift register serves both the timestamp and the memory words;
  // contents are left-aligned so the MSB is always the bit on the wire.
  localparam int SH_W  = (TS_W > WBITS) ? TS_W : WBITS;
  localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;

  localparam logic [CNT_W-1:0]  TS_LAST = CNT_W'(TS_W - 1);
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'(WBITS - 1);
  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TS     = 3'd1,
    S_RDREQ  = 3'd2,
    S_RDWAIT = 3'd3,
    S_WORD   = 3'd4,
    S_NEXT   = 3'd5
  } state_t;

  state_t cur_state, nxt_state;

  // Job queue: entry 0 is always the head. Jobs store the last word index
  // rather than a length so the field stays ADDR_W bits wide.
  logic              q_bank [2];
  logic [ADDR_W-1:0] q_lidx [2];
  logic              q_last [2];
  logic [1:0]        q_cnt;
  logic              wb;

  logic [SH_W-1:0]   sh;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;

  logic              hs;
  logic              bit_done;
  logic              last_word;
  logic              pop;
  logic              push;
  logic              push_ok;
  logic [1:0]        wr_slot;
  logic [ADDR_W-1:0] new_lidx;
  logic [SH_W-1:0]   ts_al;
  logic [SH_W-1:0]   word_al;
  logic [WBITS-1:0]  word_bits;

  assign hs        = ser_valid & ser_ready;
  assign bit_done  = hs && (cnt == '0);
  assign last_word = (idx == q_lidx[0]);
  assign pop       = (cur_state == S_WORD) && bit_done && last_word;

  // bank_full always means a whole bank, even when acq_done coincides.
  assign push     = bank_full | acq_done;
  assign new_lidx = (acq_done && !bank_full)
                    ? ((last_addr > MAX_IDX) ? MAX_IDX : last_addr)
                    : MAX_IDX;

  // A pop on the same edge frees the slot a push would otherwise lack.
  assign wr_slot = 2'(q_cnt - {1'b0, pop});
  assign push_ok = push && (wr_slot != 2'd2);

`ifdef READOUT_PARITY_EN
  assign word_bits = {rd_data, ^rd_data};
`else
  assign word_bits = rd_data;
`endif

  assign ts_al   = SH_W'(timestamp) << (SH_W - TS_W);
  assign word_al = SH_W'(word_bits) << (SH_W - WBITS);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   if (q_cnt != 2'd0) nxt_state = S_TS;
      S_TS:     if (bit_done) nxt_state = S_RDREQ;
      S_RDREQ:  nxt_state = S_RDWAIT;
      S_RDWAIT: nxt_state = S_WORD;
      S_WORD: begin
        if (bit_done) begin
          if (!last_word)     nxt_state = S_RDREQ;
          else if (q_last[0]) nxt_state = S_IDLE;
          else                nxt_state = S_NEXT;
        end
      end
      S_NEXT:   if (q_cnt != 2'd0) nxt_state = S_RDREQ;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ser_valid   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (cur_state)
      S_TS: begin
        ser_valid   = 1'b1;
        frame_start = (cnt == TS_LAST);
      end
      S_RDREQ: begin
        rd_en   = 1'b1;
        rd_addr = {q_bank[0], idx};
      end
      S_WORD: begin
        ser_valid = 1'b1;
        frame_end = (cnt == '0) && last_word && q_last[0];
      end
      default: ;
    endcase
  end

  assign ser_data = ser_valid & sh[SH_W-1];
  assign busy     = (cur_state != S_IDLE) || (q_cnt != 2'd0);
  assign state    = cur_state;

  // Job queue, write-bank pointer and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      q_cnt    <= 2'd0;
      wb       <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_bank[i] <= 1'b0;
        q_lidx[i] <= '0;
        q_last[i] <= 1'b0;
      end
    end else begin
      if (push) wb <= ~wb;
      if (pop) begin
        q_bank[0] <= q_bank[1];
        q_lidx[0] <= q_lidx[1];
        q_last[0] <= q_last[1];
      end
      // Placed after the pop shift so a push into slot 0 wins.
      if (push_ok) begin
        q_bank[wr_slot[0]] <= wb;
        q_lidx[wr_slot[0]] <= new_lidx;
        q_last[wr_slot[0]] <= acq_done;
      end
      if (push && !push_ok) overflow <= 1'b1;
      q_cnt <= 2'(wr_slot + {1'b0, push_ok});
    end
  end

  // Shift register, bit counter and word index
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (q_cnt != 2'd0) begin
            sh  <= ts_al;
            cnt <= TS_LAST;
          end
        end
        S_TS: begin
          if (hs) begin
            if (cnt == '0) begin
              idx <= '0;
            end else begin
              sh  <= sh << 1;
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_RDWAIT: begin
          sh  <= word_al;
          cnt <= WD_LAST;
        end
        S_WORD: begin
          if (hs) begin
            if (cnt == '0) begin
              if (!last_word) idx <= idx + 1'b1;
            end else begin
              sh  <= sh << 1;
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (q_cnt != 2'd0) idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spectro_readout_seq.sv
// tb/tb_spectro_readout_seq.sv - directed scoreboard bench for spectro_readout_seq

module tb_spectro_readout_seq;

  localparam int TS_W   = 8;
  localparam int WORD_W = 4;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              bank_full = 1'b0;
  logic              acq_done = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [TS_W-1:0]   timestamp = 8'hA5;
  logic              rd_en;
  logic [ADDR_W:0]   rd_addr;
  logic [WORD_W-1:0] rd_data = '0;
  logic              ser_data;
  logic              ser_valid;
  logic              ser_ready = 1'b1;
  logic              frame_start;
  logic              frame_end;
  logic              busy;
  logic              overflow;
  logic [2:0]        state;

  spectro_readout_seq #(
    .TS_W(TS_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .bank_full(bank_full), .acq_done(acq_done),
    .last_addr(last_addr), .timestamp(timestamp), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .ser_data(ser_data),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] mem [16];

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  typedef struct packed {
    logic d;
    logic fs;
    logic fe;
  } exp_t;

  exp_t        exp_q [$];
  logic [3:0]  addr_q [$];
  int          tests = 0;
  int          fails = 0;
  logic        tb_wb = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Compares everything the DUT presents in the coming edge, then advances.
  task automatic step();
    exp_t e;
    if (!reset) begin
      if (rd_en) begin
        if (addr_q.size() == 0) check("rd_unexpected", 32'(rd_en), 32'd0);
        else check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
      if (ser_valid && ser_ready) begin
        if (exp_q.size() == 0) begin
          check("bit_unexpected", 32'(ser_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ser_data", 32'(ser_data), 32'(e.d));
          check("frame_start", 32'(frame_start), 32'(e.fs));
          check("frame_end", 32'(frame_end), 32'(e.fe));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic bank, input int nwords, input bit first, input bit last);
    exp_t       e;
    logic [3:0] a;
    logic [WORD_W-1:0] w;
    if (first) begin
      for (int i = TS_W - 1; i >= 0; i--) begin
        e.d = timestamp[i]; e.fs = (i == TS_W - 1); e.fe = 1'b0;
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < nwords; k++) begin
      a = {bank, 3'(k)};
      addr_q.push_back(a);
      w = mem[a];
      for (int b = WORD_W - 1; b >= 0; b--) begin
        e.d = w[b]; e.fs = 1'b0; e.fe = 1'b0;
        exp_q.push_back(e);
      end
`ifdef READOUT_PARITY_EN
      e.d = ^w; e.fs = 1'b0; e.fe = 1'b0;
      exp_q.push_back(e);
`endif
    end
    if (last) begin
      e = exp_q.pop_back();
      e.fe = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic bf, input logic ad, input logic [ADDR_W-1:0] la);
    bank_full = bf; acq_done = ad; last_addr = la;
    step();
    bank_full = 1'b0; acq_done = 1'b0; last_addr = '0;
    tb_wb = ~tb_wb;
  endtask

  task automatic drain(input bit want_idle);
    for (int i = 0; i < 400 &&
         !(exp_q.size() == 0 && addr_q.size() == 0 && (!want_idle || !busy)); i++)
      step();
    check("drain_left", 32'(exp_q.size() + addr_q.size()), 32'd0);
    if (want_idle) check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 200 && state != s; i++) step();
    check("wait_state", 32'(state), 32'(s));
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    tb_wb = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 4'h3; mem[1] = 4'hC; mem[2] = 4'h6; mem[3] = 4'h9;
    mem[8] = 4'hA; mem[9] = 4'h5; mem[10] = 4'hF; mem[11] = 4'h1;

    // Reset state
    step(); step();
    reset_dut();
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(ser_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_fs_fe", 32'({frame_start, frame_end}), 32'd0);

    // Short event with latency check
    push_job(tb_wb, 2, 1, 1);
    pulse(1'b0, 1'b1, 3'd1);
    check("lat_valid_early", 32'(ser_valid), 32'd0);
    step();
    check("lat_valid", 32'(ser_valid), 32'd1);
    check("lat_frame_start", 32'(frame_start), 32'd1);
    drain(1);
    check("short_idle", 32'(state), 32'd0);

    // Long event spanning two banks, then a fresh event proving wb is back at 0
    reset_dut();
    push_job(tb_wb, 4, 1, 0);
    pulse(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 30; i++) step();
    push_job(tb_wb, 1, 0, 1);
    pulse(1'b0, 1'b1, 3'd0);
    drain(1);
    push_job(tb_wb, 1, 1, 1);
    pulse(1'b0, 1'b1, 3'd0);
    drain(1);

    // Backpressure mid-word
    reset_dut();
    push_job(tb_wb, 4, 1, 1);
    pulse(1'b0, 1'b1, 3'd3);
    wait_state(3'd4);
    step(); step();
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_state", 32'(state), 32'd4);
      check("bp_valid", 32'(ser_valid), 32'd1);
      check("bp_data", 32'(ser_data), 32'(exp_q[0].d));
    end
    ser_ready = 1'b1;
    drain(1);

    // last_addr beyond the bank clamps to a full bank
    push_job(tb_wb, 4, 1, 1);
    pulse(1'b0, 1'b1, 3'd6);
    drain(1);

    // Overflow: third job dropped, flag sticky until reset
    reset_dut();
    ser_ready = 1'b0;
    push_job(tb_wb, 4, 1, 0);
    pulse(1'b1, 1'b0, 3'd0);
    push_job(tb_wb, 4, 0, 0);
    pulse(1'b1, 1'b0, 3'd0);
    check("ovf_before", 32'(overflow), 32'd0);
    pulse(1'b1, 1'b0, 3'd0);
    check("ovf_set", 32'(overflow), 32'd1);
    ser_ready = 1'b1;
    drain(0);
    check("ovf_next_state", 32'(state), 32'd5);
    push_job(tb_wb, 1, 0, 1);
    pulse(1'b0, 1'b1, 3'd0);
    drain(1);
    check("ovf_held", 32'(overflow), 32'd1);
    reset_dut();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Simultaneous bank_full + acq_done: one full-length, final job
    push_job(tb_wb, 4, 1, 1);
    pulse(1'b1, 1'b1, 3'd0);
    drain(1);
    push_job(tb_wb, 1, 1, 1);
    pulse(1'b0, 1'b1, 3'd0);
    drain(1);

    // Reset during WORD_SHIFT aborts the frame
    reset_dut();
    push_job(tb_wb, 4, 1, 1);
    pulse(1'b0, 1'b1, 3'd3);
    wait_state(3'd4);
    step();
    reset_dut();
    check("abort_state", 32'(state), 32'd0);
    check("abort_valid", 32'(ser_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    push_job(tb_wb, 2, 1, 1);
    pulse(1'b0, 1'b1, 3'd1);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
